// File: rtl/axis_frame_sum.sv
// axis_frame_sum: accumulates signed fixed-point AXI-Stream samples over a
// tlast-delimited frame (or max_len samples) and emits one saturated sum beat
// carrying the sample count and overflow/truncation flags.
module axis_frame_sum #(
   parameter int DATA_WIDTH = 8,
   parameter int FRAC_WIDTH = 6,
   parameter int INT_WIDTH  = 2,
   parameter int ACC_WIDTH  = 20,
   parameter int MAX_LEN    = 2048,
   parameter int CNT_WIDTH  = 12
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   output logic [ACC_WIDTH-1:0]  m_axis_tdata,
   output logic [CNT_WIDTH-1:0]  m_axis_tcount,
   output logic                  m_axis_tovf,
   output logic                  m_axis_ttrunc,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast
);

   typedef enum logic {S_ACCUM = 1'b0, S_OUTPUT = 1'b1} state_t;

   localparam logic [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
   localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_LEN);

   // Reject parameter sets that break the Q-format or count assumptions.
   if (INT_WIDTH + FRAC_WIDTH != DATA_WIDTH) begin : g_bad_fmt
      $error("axis_frame_sum: INT_WIDTH + FRAC_WIDTH must equal DATA_WIDTH");
   end
   if (ACC_WIDTH < DATA_WIDTH) begin : g_bad_acc
      $error("axis_frame_sum: ACC_WIDTH must be >= DATA_WIDTH");
   end
   if (MAX_LEN >= (1 << CNT_WIDTH)) begin : g_bad_cnt
      $error("axis_frame_sum: CNT_WIDTH too narrow for MAX_LEN");
   end

   state_t                 state_q, state_d;
   logic [ACC_WIDTH-1:0]   acc_q, acc_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic                   ovf_q, ovf_d;
   logic                   rdy_q, rdy_d;
   logic [ACC_WIDTH-1:0]   out_sum_q, out_sum_d;
   logic [CNT_WIDTH-1:0]   out_cnt_q, out_cnt_d;
   logic                   out_ovf_q, out_ovf_d;
   logic                   out_trunc_q, out_trunc_d;

   logic signed [ACC_WIDTH:0] acc_ext, smp_ext, sum_wide;
   logic [ACC_WIDTH-1:0]      acc_sat;
   logic                      clamp;
   logic [CNT_WIDTH-1:0]      cnt_inc;
   logic                      hit_max;
   logic                      accept;

   // Saturating add of the sign-extended sample into one guard bit of headroom.
   always_comb begin
      acc_ext  = {acc_q[ACC_WIDTH-1], acc_q};
      smp_ext  = (ACC_WIDTH+1)'($signed(s_axis_tdata));
      sum_wide = acc_ext + smp_ext;
      clamp    = sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1];
      acc_sat  = sum_wide[ACC_WIDTH-1:0];
      if (clamp) acc_sat = sum_wide[ACC_WIDTH] ? SAT_MIN : SAT_MAX;
      cnt_inc  = cnt_q + CNT_WIDTH'(1);
      hit_max  = cnt_inc == MAX_CNT;
      accept   = s_axis_tvalid && rdy_q;
   end

   // Next-state: accumulate in ACCUM, latch result at frame end, hold in OUTPUT.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      out_sum_d   = out_sum_q;
      out_cnt_d   = out_cnt_q;
      out_ovf_d   = out_ovf_q;
      out_trunc_d = out_trunc_q;
      case (state_q)
         S_ACCUM: begin
            if (accept) begin
               acc_d = acc_sat;
               cnt_d = cnt_inc;
               ovf_d = ovf_q | clamp;
               if (s_axis_tlast || hit_max) begin
                  out_sum_d   = acc_sat;
                  out_cnt_d   = cnt_inc;
                  out_ovf_d   = ovf_q | clamp;
                  out_trunc_d = hit_max && !s_axis_tlast;
                  state_d     = S_OUTPUT;
               end
            end
         end
         S_OUTPUT: begin
            if (m_axis_tready) begin
               acc_d   = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
               state_d = S_ACCUM;
            end
         end
         default: state_d = S_ACCUM;
      endcase
      // Registered ready keeps tready low until the first edge after reset.
      rdy_d = state_d == S_ACCUM;
   end

   // State and datapath registers, cleared asynchronously by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_ACCUM;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         rdy_q       <= 1'b0;
         out_sum_q   <= '0;
         out_cnt_q   <= '0;
         out_ovf_q   <= 1'b0;
         out_trunc_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         rdy_q       <= rdy_d;
         out_sum_q   <= out_sum_d;
         out_cnt_q   <= out_cnt_d;
         out_ovf_q   <= out_ovf_d;
         out_trunc_q <= out_trunc_d;
      end
   end

   assign s_axis_tready = rdy_q;
   assign m_axis_tvalid = state_q == S_OUTPUT;
   assign m_axis_tlast  = state_q == S_OUTPUT;
   assign m_axis_tdata  = out_sum_q;
   assign m_axis_tcount = out_cnt_q;
   assign m_axis_tovf   = out_ovf_q;
   assign m_axis_ttrunc = out_trunc_q;

endmodule

// File: tb/tb_axis_frame_sum.sv
// Directed bench for axis_frame_sum: three instances share the input stream
// (default, 10-bit accumulator, max_len = 8); each test checks one of them.
module tb_axis_frame_sum;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] s_tdata;
   logic       s_tvalid, s_tlast, m_tready;

   logic        a_rdy, a_vld, a_last, a_ovf, a_trunc;
   logic [19:0] a_data;
   logic [11:0] a_cnt;
   logic        b_rdy, b_vld, b_last, b_ovf, b_trunc;
   logic [9:0]  b_data;
   logic [11:0] b_cnt;
   logic        t_rdy, t_vld, t_last, t_ovf, t_trunc;
   logic [19:0] t_data;
   logic [3:0]  t_cnt;

   int pass_cnt = 0;
   int total    = 0;

   always #5 clk = ~clk;

   axis_frame_sum u_a (
      .clk(clk), .reset(reset),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(a_rdy),
      .s_axis_tlast(s_tlast),
      .m_axis_tdata(a_data), .m_axis_tcount(a_cnt), .m_axis_tovf(a_ovf),
      .m_axis_ttrunc(a_trunc), .m_axis_tvalid(a_vld), .m_axis_tready(m_tready),
      .m_axis_tlast(a_last));

   axis_frame_sum #(.ACC_WIDTH(10)) u_b (
      .clk(clk), .reset(reset),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(b_rdy),
      .s_axis_tlast(s_tlast),
      .m_axis_tdata(b_data), .m_axis_tcount(b_cnt), .m_axis_tovf(b_ovf),
      .m_axis_ttrunc(b_trunc), .m_axis_tvalid(b_vld), .m_axis_tready(m_tready),
      .m_axis_tlast(b_last));

   axis_frame_sum #(.MAX_LEN(8), .CNT_WIDTH(4)) u_t (
      .clk(clk), .reset(reset),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(t_rdy),
      .s_axis_tlast(s_tlast),
      .m_axis_tdata(t_data), .m_axis_tcount(t_cnt), .m_axis_tovf(t_ovf),
      .m_axis_ttrunc(t_trunc), .m_axis_tvalid(t_vld), .m_axis_tready(m_tready),
      .m_axis_tlast(t_last));

   function automatic logic rdy(input int sel);
      case (sel)
         1:       return b_rdy;
         2:       return t_rdy;
         default: return a_rdy;
      endcase
   endfunction

   // Present one beat and hold it until the selected instance accepts it.
   task automatic beat(input logic [7:0] d, input logic l, input int sel);
      int n;
      n = 0;
      s_tdata = d; s_tvalid = 1'b1; s_tlast = l;
      while (!rdy(sel) && n < 50) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 50) begin
         total++;
         $display("FAIL beat_timeout: tready never rose for instance %0d", sel);
      end
      @(posedge clk); #1;
      s_tvalid = 1'b0; s_tlast = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; m_tready = 1'b1;
      #3;
      total++;
      if ({a_rdy, a_vld, a_last, a_ovf, a_trunc, a_data, a_cnt} !== '0)
         $display("FAIL reset_outs: got %h required 0",
                  {a_rdy, a_vld, a_last, a_ovf, a_trunc, a_data, a_cnt});
      else pass_cnt++;
      @(posedge clk); #1 reset = 1'b1;
      total++;
      if (a_rdy !== 1'b0) $display("FAIL reset_rdy_release: got %b required 0", a_rdy);
      else pass_cnt++;
      @(posedge clk); #1;
      total++;
      if (a_rdy !== 1'b1) $display("FAIL reset_rdy_edge: got %b required 1", a_rdy);
      else pass_cnt++;
   endtask

   task automatic test_sum_pos();
      do_reset();
      m_tready = 1'b1;
      for (int i = 0; i < 10; i++) beat(8'h40, 1'b0, 0);
      beat(8'h40, 1'b1, 0);
      total++;
      if ({a_vld, a_last, a_data, a_cnt, a_ovf, a_trunc} !== {1'b1, 1'b1, 20'h002C0, 12'd11, 1'b0, 1'b0})
         $display("FAIL pos_frame: got vld=%b last=%b data=%h cnt=%0d ovf=%b trunc=%b required 1 1 002c0 11 0 0",
                  a_vld, a_last, a_data, a_cnt, a_ovf, a_trunc);
      else pass_cnt++;
      @(posedge clk); #1;
      total++;
      if ({a_vld, a_last, a_rdy} !== 3'b001)
         $display("FAIL pos_after_hs: got vld/last/rdy=%b required 001", {a_vld, a_last, a_rdy});
      else pass_cnt++;
   endtask

   task automatic test_sum_neg();
      do_reset();
      m_tready = 1'b1;
      for (int i = 0; i < 3; i++) beat(8'hC0, 1'b0, 0);
      beat(8'hC0, 1'b1, 0);
      total++;
      if ({a_vld, a_data, a_cnt} !== {1'b1, 20'hFFF00, 12'd4})
         $display("FAIL neg_frame: got vld=%b data=%h cnt=%0d required 1 fff00 4", a_vld, a_data, a_cnt);
      else pass_cnt++;
      beat(8'h80, 1'b1, 0);
      total++;
      if ({a_vld, a_data, a_cnt, a_ovf, a_trunc} !== {1'b1, 20'hFFF80, 12'd1, 1'b0, 1'b0})
         $display("FAIL single_sample: got vld=%b data=%h cnt=%0d ovf=%b trunc=%b required 1 fff80 1 0 0",
                  a_vld, a_data, a_cnt, a_ovf, a_trunc);
      else pass_cnt++;
   endtask

   task automatic test_saturate();
      do_reset();
      m_tready = 1'b1;
      for (int i = 0; i < 15; i++) beat(8'h7F, 1'b0, 1);
      beat(8'h7F, 1'b1, 1);
      total++;
      if ({b_vld, b_data, b_cnt, b_ovf, b_trunc} !== {1'b1, 10'h1FF, 12'd16, 1'b1, 1'b0})
         $display("FAIL sat_pos: got vld=%b data=%h cnt=%0d ovf=%b trunc=%b required 1 1ff 16 1 0",
                  b_vld, b_data, b_cnt, b_ovf, b_trunc);
      else pass_cnt++;
      beat(8'h01, 1'b0, 1);
      beat(8'h01, 1'b1, 1);
      total++;
      if ({b_vld, b_data, b_cnt, b_ovf} !== {1'b1, 10'd2, 12'd2, 1'b0})
         $display("FAIL sat_clear: got vld=%b data=%h cnt=%0d ovf=%b required 1 002 2 0",
                  b_vld, b_data, b_cnt, b_ovf);
      else pass_cnt++;
      for (int i = 0; i < 15; i++) beat(8'h80, 1'b0, 1);
      beat(8'h80, 1'b1, 1);
      total++;
      if ({b_vld, b_data, b_cnt, b_ovf} !== {1'b1, 10'h200, 12'd16, 1'b1})
         $display("FAIL sat_neg: got vld=%b data=%h cnt=%0d ovf=%b required 1 200 16 1",
                  b_vld, b_data, b_cnt, b_ovf);
      else pass_cnt++;
   endtask

   task automatic test_backpressure();
      do_reset();
      m_tready = 1'b0;
      beat(8'h40, 1'b0, 0);
      beat(8'h40, 1'b0, 0);
      beat(8'h40, 1'b1, 0);
      // Offer a beat that must not be consumed while the result is stalled.
      s_tvalid = 1'b1; s_tdata = 8'h7F; s_tlast = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         total++;
         if ({a_vld, a_rdy, a_data, a_cnt, a_ovf, a_trunc} !== {1'b1, 1'b0, 20'd192, 12'd3, 1'b0, 1'b0})
            $display("FAIL bp_hold%0d: got vld=%b rdy=%b data=%h cnt=%0d required 1 0 000c0 3",
                     i, a_vld, a_rdy, a_data, a_cnt);
         else pass_cnt++;
      end
      m_tready = 1'b1; s_tdata = 8'h01; s_tlast = 1'b1;
      @(posedge clk); #1;
      total++;
      if ({a_vld, a_rdy} !== 2'b01)
         $display("FAIL bp_handshake: got vld/rdy=%b required 01", {a_vld, a_rdy});
      else pass_cnt++;
      @(posedge clk); #1;
      s_tvalid = 1'b0; s_tlast = 1'b0;
      total++;
      if ({a_vld, a_data, a_cnt} !== {1'b1, 20'd1, 12'd1})
         $display("FAIL bp_next_accept: got vld=%b data=%h cnt=%0d required 1 00001 1", a_vld, a_data, a_cnt);
      else pass_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic test_truncate();
      do_reset();
      m_tready = 1'b1;
      for (int i = 0; i < 8; i++) beat(8'h01, 1'b0, 2);
      total++;
      if ({t_vld, t_data, t_cnt, t_trunc, t_ovf} !== {1'b1, 20'd8, 4'd8, 1'b1, 1'b0})
         $display("FAIL trunc_frame: got vld=%b data=%h cnt=%0d trunc=%b ovf=%b required 1 00008 8 1 0",
                  t_vld, t_data, t_cnt, t_trunc, t_ovf);
      else pass_cnt++;
      beat(8'h01, 1'b0, 2);
      beat(8'h01, 1'b0, 2);
      beat(8'h01, 1'b1, 2);
      total++;
      if ({t_vld, t_data, t_cnt, t_trunc} !== {1'b1, 20'd3, 4'd3, 1'b0})
         $display("FAIL trunc_rest: got vld=%b data=%h cnt=%0d trunc=%b required 1 00003 3 0",
                  t_vld, t_data, t_cnt, t_trunc);
      else pass_cnt++;
      for (int i = 0; i < 7; i++) beat(8'h01, 1'b0, 2);
      beat(8'h01, 1'b1, 2);
      total++;
      if ({t_vld, t_data, t_cnt, t_trunc} !== {1'b1, 20'd8, 4'd8, 1'b0})
         $display("FAIL tlast_at_max: got vld=%b data=%h cnt=%0d trunc=%b required 1 00008 8 0",
                  t_vld, t_data, t_cnt, t_trunc);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_frame();
      do_reset();
      m_tready = 1'b1;
      beat(8'h40, 1'b0, 0);
      beat(8'h40, 1'b1, 0);
      total++;
      if ({a_vld, a_data} !== {1'b1, 20'd128})
         $display("FAIL pre_reset_frame: got vld=%b data=%h required 1 00080", a_vld, a_data);
      else pass_cnt++;
      for (int i = 0; i < 5; i++) beat(8'h40, 1'b0, 0);
      #3 reset = 1'b0;
      #1;
      total++;
      if ({a_rdy, a_vld, a_last, a_ovf, a_trunc, a_data, a_cnt} !== '0)
         $display("FAIL mid_reset_outs: got %h required 0",
                  {a_rdy, a_vld, a_last, a_ovf, a_trunc, a_data, a_cnt});
      else pass_cnt++;
      @(posedge clk); #1 reset = 1'b1;
      beat(8'h40, 1'b0, 0);
      beat(8'h40, 1'b0, 0);
      beat(8'h40, 1'b1, 0);
      total++;
      if ({a_vld, a_data, a_cnt, a_ovf, a_trunc} !== {1'b1, 20'd192, 12'd3, 1'b0, 1'b0})
         $display("FAIL post_reset_frame: got vld=%b data=%h cnt=%0d required 1 000c0 3", a_vld, a_data, a_cnt);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_sum_pos();
      test_sum_neg();
      test_saturate();
      test_backpressure();
      test_truncate();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
